// File: rtl/time_set_ctrl_12hr.sv
// Button-driven preset editor for the 12-hour clock: seeds shadow registers from
// the running time, edits hour/min/sec with auto-repeat, then issues a low load pulse.
module time_set_ctrl_12hr #(
    parameter int LOAD_CYCLES = 2,
    parameter int RPT_DELAY   = 500,
    parameter int RPT_PERIOD  = 100,
    parameter int TIMEOUT     = 10000,
    parameter int BLINK_HALF  = 250
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       btn_mode_i,
    input  logic       btn_inc_i,
    input  logic       btn_dec_i,
    input  logic [4:0] hour_i,
    input  logic [5:0] min_i,
    input  logic [5:0] sec_i,
    output logic [4:0] hourset_o,
    output logic [5:0] minset_o,
    output logic [5:0] secset_o,
    output logic       load_n_o,
    output logic       editing_o,
    output logic [1:0] field_o,
    output logic       blink_o
);

    typedef enum logic [2:0] {
        IDLE,
        EDIT_HR,
        EDIT_MIN,
        EDIT_SEC,
        COMMIT
    } state_t;

    localparam int HOLD_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam int IDLE_W   = $clog2(TIMEOUT + 1);
    localparam int BLINK_W  = $clog2(BLINK_HALF + 1);
    localparam int LOAD_W   = $clog2(LOAD_CYCLES + 1);

    localparam logic [HOLD_W-1:0]  RPT_DELAY_C  = HOLD_W'(RPT_DELAY);
    localparam logic [HOLD_W-1:0]  RPT_PERIOD_C = HOLD_W'(RPT_PERIOD);
    localparam logic [IDLE_W-1:0]  TIMEOUT_LAST = IDLE_W'(TIMEOUT - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST   = BLINK_W'(BLINK_HALF - 1);
    localparam logic [LOAD_W-1:0]  LOAD_LAST    = LOAD_W'(LOAD_CYCLES);

    function automatic logic [4:0] clamp_hour(input logic [4:0] h);
        return (h == 5'd0 || h > 5'd12) ? 5'd12 : h;
    endfunction

    function automatic logic [5:0] clamp_sexa(input logic [5:0] v);
        return (v > 6'd59) ? 6'd0 : v;
    endfunction

    function automatic logic [4:0] hour_step(input logic [4:0] h, input logic up);
        if (up) return (h == 5'd12) ? 5'd1 : h + 5'd1;
        return (h == 5'd1) ? 5'd12 : h - 5'd1;
    endfunction

    function automatic logic [5:0] sexa_step(input logic [5:0] v, input logic up);
        if (up) return (v == 6'd59) ? 6'd0 : v + 6'd1;
        return (v == 6'd0) ? 6'd59 : v - 6'd1;
    endfunction

    state_t             state_q, state_d;
    logic               mode_prev_q, inc_prev_q, dec_prev_q;
    logic [4:0]         hour_q, hour_d;
    logic [5:0]         min_q, min_d;
    logic [5:0]         sec_q, sec_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d, hold_next;
    logic               rpt_active_q, rpt_active_d;
    logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
    logic [LOAD_W-1:0]  load_cnt_q, load_cnt_d;
    logic               load_n_q, load_n_d;
    logic               blink_q, blink_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;

    logic mode_press, inc_press, dec_press, any_press;
    logic step, restart;

    assign mode_press = btn_mode_i & ~mode_prev_q;
    assign inc_press  = btn_inc_i & ~inc_prev_q;
    assign dec_press  = btn_dec_i & ~dec_prev_q;
    assign any_press  = mode_press | inc_press | dec_press;

    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
        state_d      = state_q;
        hour_d       = hour_q;
        min_d        = min_q;
        sec_d        = sec_q;
        hold_cnt_d   = hold_cnt_q;
        hold_next    = hold_cnt_q + 1'b1;
        rpt_active_d = rpt_active_q;
        idle_cnt_d   = idle_cnt_q;
        load_cnt_d   = load_cnt_q;
        load_n_d     = 1'b1;
        blink_d      = blink_q;
        blink_cnt_d  = blink_cnt_q;
        step         = 1'b0;
        restart      = 1'b0;

        case (state_q)
            IDLE: begin
                hold_cnt_d   = '0;
                rpt_active_d = 1'b0;
                idle_cnt_d   = '0;
                load_cnt_d   = '0;
                if (mode_press) begin
                    state_d = EDIT_HR;
                    hour_d  = clamp_hour(hour_i);
                    min_d   = clamp_sexa(min_i);
                    sec_d   = clamp_sexa(sec_i);
                    restart = 1'b1;
                end
            end

            EDIT_HR, EDIT_MIN, EDIT_SEC: begin
                if (mode_press) begin
                    // Mode beats a simultaneous inc/dec: advance field, leave value alone.
                    case (state_q)
                        EDIT_HR:  state_d = EDIT_MIN;
                        EDIT_MIN: state_d = EDIT_SEC;
                        default:  state_d = COMMIT;
                    endcase
                    hold_cnt_d   = '0;
                    rpt_active_d = 1'b0;
                    idle_cnt_d   = '0;
                    load_cnt_d   = '0;
                    restart      = 1'b1;
                end else if (!any_press && idle_cnt_q == TIMEOUT_LAST) begin
                    state_d    = IDLE;
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = any_press ? '0 : idle_cnt_q + 1'b1;
                    if (btn_inc_i && btn_dec_i) begin
                        hold_cnt_d   = '0;
                        rpt_active_d = 1'b0;
                    end else if (inc_press || dec_press) begin
                        step         = 1'b1;
                        hold_cnt_d   = '0;
                        rpt_active_d = 1'b0;
                    end else if (btn_inc_i || btn_dec_i) begin
                        // First repeat after RPT_DELAY held cycles, then every RPT_PERIOD.
                        if ((!rpt_active_q && hold_next == RPT_DELAY_C) ||
                            ( rpt_active_q && hold_next == RPT_PERIOD_C)) begin
                            step         = 1'b1;
                            hold_cnt_d   = '0;
                            rpt_active_d = 1'b1;
                        end else begin
                            hold_cnt_d = hold_next;
                        end
                    end else begin
                        hold_cnt_d   = '0;
                        rpt_active_d = 1'b0;
                    end

                    if (step) begin
                        restart = 1'b1;
                        case (state_q)
                            EDIT_HR:  hour_d = hour_step(hour_q, btn_inc_i);
                            EDIT_MIN: min_d  = sexa_step(min_q, btn_inc_i);
                            default:  sec_d  = sexa_step(sec_q, btn_inc_i);
                        endcase
                    end
                end
            end

            COMMIT: begin
                hold_cnt_d   = '0;
                rpt_active_d = 1'b0;
                idle_cnt_d   = '0;
                // First COMMIT cycle keeps load_n high; the next LOAD_CYCLES drive it low.
                if (load_cnt_q == LOAD_LAST) begin
                    state_d    = IDLE;
                    load_cnt_d = '0;
                end else begin
                    load_n_d   = 1'b0;
                    load_cnt_d = load_cnt_q + 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase

        if (state_d inside {EDIT_HR, EDIT_MIN, EDIT_SEC}) begin
            if (restart) begin
                blink_d     = 1'b1;
                blink_cnt_d = '0;
            end else if (blink_cnt_q == BLINK_LAST) begin
                blink_d     = ~blink_q;
                blink_cnt_d = '0;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end else begin
            blink_d     = 1'b0;
            blink_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset_i) begin
            state_q      <= IDLE;
            mode_prev_q  <= 1'b0;
            inc_prev_q   <= 1'b0;
            dec_prev_q   <= 1'b0;
            hour_q       <= 5'd12;
            min_q        <= 6'd0;
            sec_q        <= 6'd0;
            hold_cnt_q   <= '0;
            rpt_active_q <= 1'b0;
            idle_cnt_q   <= '0;
            load_cnt_q   <= '0;
            load_n_q     <= 1'b1;
            blink_q      <= 1'b0;
            blink_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            mode_prev_q  <= btn_mode_i;
            inc_prev_q   <= btn_inc_i;
            dec_prev_q   <= btn_dec_i;
            hour_q       <= hour_d;
            min_q        <= min_d;
            sec_q        <= sec_d;
            hold_cnt_q   <= hold_cnt_d;
            rpt_active_q <= rpt_active_d;
            idle_cnt_q   <= idle_cnt_d;
            load_cnt_q   <= load_cnt_d;
            load_n_q     <= load_n_d;
            blink_q      <= blink_d;
            blink_cnt_q  <= blink_cnt_d;
        end
    end

    always_comb begin
        field_o = 2'd0;
        case (state_q)
            EDIT_HR:  field_o = 2'd1;
            EDIT_MIN: field_o = 2'd2;
            EDIT_SEC: field_o = 2'd3;
            default:  field_o = 2'd0;
        endcase
    end

    assign hourset_o = hour_q;
    assign minset_o  = min_q;
    assign secset_o  = sec_q;
    assign load_n_o  = load_n_q;
    assign editing_o = (state_q != IDLE);
    assign blink_o   = blink_q;

endmodule

// File: tb/tb_time_set_ctrl_12hr.sv
// Scoreboard bench for time_set_ctrl_12hr: a cycle-level reference model pushes
// expected outputs per edge; a monitor pops and compares after each edge.
module tb_time_set_ctrl_12hr;

    localparam int LC = 2;
    localparam int RD = 5;
    localparam int RP = 3;
    localparam int TO = 20;
    localparam int BH = 4;

    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
    logic [4:0] hour_in = 5'd1;
    logic [5:0] min_in = 6'd0, sec_in = 6'd0;
    logic [4:0] hourset_o;
    logic [5:0] minset_o, secset_o;
    logic       load_n_o, editing_o, blink_o;
    logic [1:0] field_o;

    time_set_ctrl_12hr #(
        .LOAD_CYCLES(LC), .RPT_DELAY(RD), .RPT_PERIOD(RP), .TIMEOUT(TO), .BLINK_HALF(BH)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .btn_mode_i(btn_mode), .btn_inc_i(btn_inc), .btn_dec_i(btn_dec),
        .hour_i(hour_in), .min_i(min_in), .sec_i(sec_in),
        .hourset_o(hourset_o), .minset_o(minset_o), .secset_o(secset_o),
        .load_n_o(load_n_o), .editing_o(editing_o), .field_o(field_o), .blink_o(blink_o)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] hour;
        logic [5:0] min;
        logic [5:0] sec;
        logic       load_n;
        logic       editing;
        logic [1:0] field;
        logic       blink;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int low_total = 0;

    // Reference model: mode 0 idle, 1..3 editing that field, 4 committing.
    int m_mode = 0, m_h = 12, m_m = 0, m_s = 0;
    int m_k = 0, m_idle = 0, m_age = 0, m_ca = 0;
    bit m_pm = 0, m_pi = 0, m_pd = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, req, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit bm, input bit bi, input bit bd);
        bit mp, ip, dp, anyp, stepped, restart;
        exp_t e;
        restart = 0;
        if (rst) begin
            m_mode = 0; m_h = 12; m_m = 0; m_s = 0;
            m_k = 0; m_idle = 0; m_age = 0; m_ca = 0;
            m_pm = 0; m_pi = 0; m_pd = 0;
        end else begin
            mp = bm && !m_pm;
            ip = bi && !m_pi;
            dp = bd && !m_pd;
            anyp = mp || ip || dp;
            if (m_mode == 0) begin
                m_k = 0; m_idle = 0;
                if (mp) begin
                    m_mode = 1;
                    m_h = (hour_in == 0 || hour_in > 12) ? 12 : int'(hour_in);
                    m_m = (min_in > 59) ? 0 : int'(min_in);
                    m_s = (sec_in > 59) ? 0 : int'(sec_in);
                    restart = 1;
                end
            end else if (m_mode <= 3) begin
                if (mp) begin
                    m_mode = m_mode + 1;
                    m_ca = 0; m_k = 0; m_idle = 0;
                    restart = 1;
                end else if (!anyp && m_idle + 1 >= TO) begin
                    m_mode = 0; m_k = 0; m_idle = 0;
                end else begin
                    m_idle = anyp ? 0 : m_idle + 1;
                    stepped = 0;
                    if (bi && bd) m_k = 0;
                    else if (ip || dp) begin m_k = 0; stepped = 1; end
                    else if (bi || bd) begin
                        m_k++;
                        if (m_k >= RD && (m_k - RD) % RP == 0) stepped = 1;
                    end else m_k = 0;
                    if (stepped) begin
                        restart = 1;
                        if (m_mode == 1) m_h = bi ? (m_h % 12) + 1 : ((m_h == 1) ? 12 : m_h - 1);
                        else if (m_mode == 2) m_m = bi ? (m_m + 1) % 60 : (m_m + 59) % 60;
                        else m_s = bi ? (m_s + 1) % 60 : (m_s + 59) % 60;
                    end
                end
            end else begin
                m_k = 0; m_idle = 0;
                m_ca++;
                if (m_ca > LC) m_mode = 0;
            end
            m_age = restart ? 0 : m_age + 1;
            m_pm = bm; m_pi = bi; m_pd = bd;
        end
        e.hour    = 5'(m_h);
        e.min     = 6'(m_m);
        e.sec     = 6'(m_s);
        e.load_n  = !(m_mode == 4 && m_ca >= 1);
        e.editing = (m_mode != 0);
        e.field   = (m_mode >= 1 && m_mode <= 3) ? 2'(m_mode) : 2'd0;
        e.blink   = (m_mode >= 1 && m_mode <= 3) ? ((m_age / BH) % 2 == 0) : 1'b0;
        exp_q.push_back(e);
    endtask

    // Drives one cycle of inputs at the falling edge; returns just after the next rising edge.
    task automatic cyc(input bit rst, input bit bm, input bit bi, input bit bd);
        @(negedge clk);
        reset_i = rst; btn_mode = bm; btn_inc = bi; btn_dec = bd;
        model_step(rst, bm, bi, bd);
        @(posedge clk);
        #1;
    endtask

    task automatic tap(input bit bm, input bit bi, input bit bd);
        cyc(0, bm, bi, bd);
        cyc(0, 0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("hourset", int'(hourset_o), int'(e.hour));
                check("minset",  int'(minset_o),  int'(e.min));
                check("secset",  int'(secset_o),  int'(e.sec));
                check("load_n",  int'(load_n_o),  int'(e.load_n));
                check("editing", int'(editing_o), int'(e.editing));
                check("field",   int'(field_o),   int'(e.field));
                check("blink",   int'(blink_o),   int'(e.blink));
                if (load_n_o === 1'b0) low_total++;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int lt, pat, dur;
        bit bm, bi, bd, rst;

        repeat (3) cyc(1, 0, 0, 0);
        check("reset_hour", int'(hourset_o), 12);
        check("reset_load_n", int'(load_n_o), 1);

        // Full edit walk with wraps, then commit pulse width.
        hour_in = 5'd11; min_in = 6'd58; sec_in = 6'd7;
        tap(1, 0, 0);
        check("capture_hour", int'(hourset_o), 11);
        tap(0, 1, 0);
        check("hour_inc_12", int'(hourset_o), 12);
        tap(0, 1, 0);
        check("hour_wrap_1", int'(hourset_o), 1);
        tap(1, 0, 0);
        tap(0, 1, 0);
        check("min_inc_59", int'(minset_o), 59);
        tap(0, 1, 0);
        check("min_wrap_0", int'(minset_o), 0);
        tap(1, 0, 0);
        tap(0, 0, 1);
        check("sec_dec_6", int'(secset_o), 6);
        lt = low_total;
        tap(1, 0, 0);
        repeat (4) cyc(0, 0, 0, 0);
        check("commit_low_cycles", low_total - lt, LC);
        check("commit_back_idle", int'(editing_o), 0);
        check("commit_hold_hour", int'(hourset_o), 1);

        // Capture clamp, then abandon by timeout.
        hour_in = 5'd0; min_in = 6'd63; sec_in = 6'd45;
        lt = low_total;
        tap(1, 0, 0);
        check("clamp_hour", int'(hourset_o), 12);
        check("clamp_min", int'(minset_o), 0);
        repeat (TO - 3) cyc(0, 0, 0, 0);
        check("before_timeout", int'(editing_o), 1);
        repeat (2) cyc(0, 0, 0, 0);
        check("timeout_idle", int'(editing_o), 0);
        check("timeout_no_load", low_total - lt, 0);
        check("timeout_keeps_sec", int'(secset_o), 45);

        // Auto-repeat: press plus 14 held cycles from 10.
        hour_in = 5'd5; min_in = 6'd10; sec_in = 6'd30;
        tap(1, 0, 0);
        tap(1, 0, 0);
        repeat (15) cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        check("repeat_min_15", int'(minset_o), 15);

        // Simultaneous inc+dec, and mode with inc.
        tap(1, 0, 0);
        tap(0, 1, 1);
        check("incdec_sec_30", int'(secset_o), 30);
        tap(1, 0, 0);
        repeat (4) cyc(0, 0, 0, 0);
        tap(1, 0, 0);
        cyc(0, 1, 1, 0);
        check("mode_wins_field", int'(field_o), 2);
        check("mode_wins_hour", int'(hourset_o), 5);
        cyc(0, 0, 0, 0);

        // Reset mid-edit.
        tap(0, 1, 0);
        repeat (3) cyc(1, 0, 0, 0);
        check("midreset_min", int'(minset_o), 0);
        check("midreset_field", int'(field_o), 0);
        check("midreset_editing", int'(editing_o), 0);

        // Randomised sequences against the model.
        for (int n = 0; n < 400; n++) begin
            pat = $urandom_range(0, 11);
            dur = $urandom_range(1, 12);
            if ($urandom_range(0, 3) == 0) begin
                hour_in = 5'($urandom_range(0, 31));
                min_in  = 6'($urandom_range(0, 63));
                sec_in  = 6'($urandom_range(0, 63));
            end
            rst = ($urandom_range(0, 80) == 0);
            bm = (pat == 4 || pat == 5 || pat == 10);
            bi = (pat == 6 || pat == 8 || pat == 10);
            bd = (pat == 7 || pat == 8);
            if (pat == 9) dur = 25;
            if (pat == 4 || pat == 5) dur = 1;
            repeat (dur) cyc(rst, bm, bi, bd);
            cyc(0, 0, 0, 0);
        end

        repeat (2) @(posedge clk);
        #2;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl_12hr.md
Name: time_set_ctrl_12hr

Overview:
- Writer side of the 12-hour clock's preset interface.
- Turns debounced mode/inc/dec buttons into Hourset/Minset/Secset values and an active-low load pulse that drives the clock counter's reset_i.
- On entry to edit, it seeds its shadow registers from the running clock. It steps through hour, minute and second fields, then commits.
- If no button is pressed for a set time, it abandons the edit without committing.

Parameters:
- LOAD_CYCLES, 2, width of the load_n_o low pulse in clk_i cycles (must be ≥1).
- RPT_DELAY, 500, cycles inc/dec must be held before auto-repeat starts.
- RPT_PERIOD, 100, cycles between auto-repeat steps while still held.
- TIMEOUT, 10000, idle cycles in any edit state before abandoning to IDLE.
- BLINK_HALF, 250, half-period of blink_o in cycles.

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  synchronous, active-high reset
- btn_mode_i  in  1  mode button, level, already synchronized and debounced
- btn_inc_i  in  1  increment button, level, already synchronized and debounced
- btn_dec_i  in  1  decrement button, level, already synchronized and debounced
- hour_i  in  5  running clock hour, 1..12
- min_i  in  6  running clock minute
- sec_i  in  6  running clock second
- hourset_o  out  5  preset hour, to the clock's Hourset input
- minset_o  out  6  preset minute, to the clock's Minset input
- secset_o  out  6  preset second, to the clock's Secset input
- load_n_o  out  1  active-low load strobe, to the clock's reset_i
- editing_o  out  1  high in any edit or commit state
- field_o  out  2  field being edited: 0 none, 1 hour, 2 min, 3 sec
- blink_o  out  1  display blink for the selected field

Behaviour:
- Reset (reset_i high at a posedge): all registers return to reset values.
  - State=IDLE.
  - hourset_o=12, minset_o=0, secset_o=0.
  - load_n_o=1, editing_o=0, field_o=0, blink_o=0.
  - All counters cleared; previous-button registers cleared.
  - Reset overrides everything, including a commit in progress; load_n_o returns high the cycle after.
- Press detection: press = btn & ~btn_prev, with btn_prev registered every cycle. A press acts at the same edge where it is first sampled, so outputs change 1 cycle after the button rises.
- States: IDLE, EDIT_HR, EDIT_MIN, EDIT_SEC, COMMIT.
- IDLE:
  - Mode press -> EDIT_HR.
  - Same edge: capture hour_i/min_i/sec_i into the shadows.
  - Clamp on capture: hour 0 or >12 -> 12; min or sec >59 -> 0.
  - inc/dec ignored in IDLE.
- EDIT_HR -> EDIT_MIN -> EDIT_SEC on each mode press.
- EDIT_SEC: mode press -> COMMIT.
- field_o: 1 in EDIT_HR, 2 in EDIT_MIN, 3 in EDIT_SEC, 0 in IDLE and COMMIT.
- editing_o: 1 in every state except IDLE.
- Increment/decrement in an edit state (selected field only):
  - Hour: 12 inc -> 1; 1 dec -> 12.
  - Min/sec: 59 inc -> 0; 0 dec -> 59.
  - No carry between fields.
- Simultaneous events:
  - inc and dec both pressed, or both held: no change; the repeat counter is cleared.
  - Mode press together with inc/dec: mode wins; the field value is unchanged.
- Auto-repeat:
  - A hold counter starts on the press.
  - After RPT_DELAY cycles of continuous hold, one extra step, then one step every RPT_PERIOD cycles.
  - Release clears the counter.
- Timeout:
  - Idle counter clears on any press.
  - After TIMEOUT consecutive cycles with no press in an EDIT state -> IDLE.
  - Shadows keep their values; no load pulse; load_n_o stays 1.
- COMMIT:
  - load_n_o=0 for exactly LOAD_CYCLES cycles, starting the cycle after entry.
  - Then -> IDLE with load_n_o=1.
  - hourset_o/minset_o/secset_o are stable throughout COMMIT.
  - All buttons are ignored in COMMIT.
- Set outputs: hourset_o/minset_o/secset_o are the shadow registers and are always driven, including outside COMMIT.
- blink_o:
  - Toggles every BLINK_HALF cycles in EDIT states.
  - Restarts at 1 on every state change and on every inc/dec step.
  - Forced 0 in IDLE and COMMIT.

Test Plan:
- Reset held 3 cycles mid-edit -> hourset_o=12, minset_o=0, secset_o=0, load_n_o=1, field_o=0, editing_o=0.
- hour_i=11, min_i=58, sec_i=7; mode press; inc ×2 -> hourset_o=11, 12, then 1; mode; inc ×2 -> minset_o=59, then 0; mode; dec -> secset_o=6; mode -> load_n_o low exactly 2 cycles; then IDLE.
- Capture with hour_i=0, min_i=63 -> hourset_o=12, minset_o=0.
- RPT_DELAY=5, RPT_PERIOD=3, EDIT_MIN from 10, inc held 14 cycles -> steps at press and at hold cycles 5, 8, 11, 14, giving min 15.
- inc and dec pressed together in EDIT_SEC at 30 -> secset_o stays 30; mode together with inc in EDIT_HR -> field_o=2, hour unchanged.
- TIMEOUT=20, enter EDIT_HR, no presses for 20 cycles -> IDLE, load_n_o never low.
